// File: rtl/ahbl_master_port.sv
// AHB-Lite master port: turns a CPU request/response bus into pipelined AHB-Lite
// transfers (address stage AP, data stage DP), with error cancel, alignment check and watchdog.
module ahbl_master_port #(
  parameter int         ADDR_WIDTH     = 32,
  parameter logic [3:0] HPROT_VAL      = 4'b0011,
  parameter bit         ERR_CANCEL     = 1'b1,
  parameter bit         ALIGN_CHECK    = 1'b1,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HSIZE,
  output logic                  HWRITE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [31:0]           HWDATA,
  input  logic [31:0]           HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic                  err_irq,
  output logic [ADDR_WIDTH-1:0] err_addr,
  input  logic                  err_clr
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_SAT  = WD_W'(TIMEOUT_CYCLES);

  // Handshake: a request transfers when req_valid & req_ready at HCLK rise;
  // rsp_valid is a one-cycle pulse in request order with no backpressure.

  // AP stage: HADDR/HWRITE are the AP address/control registers themselves.
  logic        ap_valid;
  logic        ap_bus;      // 0 = local error entry (misaligned or cancelled), never NONSEQ
  logic [1:0]  ap_size;
  logic [31:0] ap_wdata;

  logic                  dp_valid;
  logic                  dp_bus;
  logic                  dp_wr;
  logic [ADDR_WIDTH-1:0] dp_addr;

  logic            cancel_pend;
  logic [WD_W-1:0] wd_cnt;

  logic misaligned, req_local, acc, ap_adv, dp_done, dp_err, err_first, wd_hit, err_evt;

  function automatic logic [31:0] lane_rep(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    lane_rep = {4{d[7:0]}};
      2'd1:    lane_rep = {2{d[15:0]}};
      default: lane_rep = d;
    endcase
  endfunction

  assign misaligned = (req_size == 2'd3) ||
                      ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign req_local  = ALIGN_CHECK && misaligned;

  assign req_ready = !ap_valid || (HREADY && !cancel_pend);
  assign acc       = req_valid && req_ready;
  assign ap_adv    = ap_valid && HREADY;
  assign dp_done   = dp_valid && HREADY;
  assign dp_err    = dp_done && (!dp_bus || HRESP);
  assign err_first = dp_valid && dp_bus && HRESP && !HREADY;
  assign wd_hit    = (TIMEOUT_CYCLES != 0) && dp_valid && !HREADY && (wd_cnt == WD_LAST);
  assign err_evt   = dp_err || wd_hit;

  assign HTRANS    = {ap_bus, 1'b0};
  assign HSIZE     = {1'b0, ap_size};
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid <= 1'b0;
      ap_bus   <= 1'b0;
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      ap_size  <= 2'd0;
      ap_wdata <= '0;
    end else if (acc) begin
      ap_valid <= 1'b1;
      ap_bus   <= !req_local;
      HADDR    <= req_addr;
      HWRITE   <= req_wr;
      ap_size  <= req_size;
      ap_wdata <= req_wdata;
    end else if (ap_adv) begin
      ap_valid <= 1'b0;
      ap_bus   <= 1'b0;
    end else if (ERR_CANCEL && err_first) begin
      // Withdraw the pending address; the entry now completes as a local error.
      ap_bus <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_bus   <= 1'b0;
      dp_wr    <= 1'b0;
      dp_addr  <= '0;
      HWDATA   <= '0;
    end else if (ap_adv) begin
      dp_valid <= 1'b1;
      dp_bus   <= ap_bus;
      dp_wr    <= HWRITE;
      dp_addr  <= HADDR;
      HWDATA   <= lane_rep(ap_wdata, ap_size);
    end else if (dp_done) begin
      dp_valid <= 1'b0;
      dp_bus   <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      cancel_pend <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      rsp_valid <= dp_done;
      rsp_err   <= dp_err;
      rsp_rdata <= (dp_done && dp_bus && !dp_wr && !HRESP) ? HRDATA : 32'h0;
      if (err_first)   cancel_pend <= 1'b1;
      else if (HREADY) cancel_pend <= 1'b0;
      if (!dp_valid || HREADY) wd_cnt <= '0;
      else if (wd_cnt != WD_SAT) wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // First error since the last clear owns err_addr; a clear never hides a same-cycle error.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_irq  <= 1'b0;
      err_addr <= '0;
    end else if (err_evt && (!err_irq || err_clr)) begin
      err_irq  <= 1'b1;
      err_addr <= dp_addr;
    end else if (err_clr) begin
      err_irq  <= 1'b0;
      err_addr <= '0;
    end
  end

endmodule

// File: tb/tb_ahbl_master_port.sv
// Bench for ahbl_master_port: directed scenarios plus randomized traffic against a
// request-level reference model, with a behavioural AHB-Lite slave.
module tb_ahbl_master_port;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic        err_irq;
  logic [31:0] err_addr;
  logic        err_clr = 1'b0;

  ahbl_master_port #(.TIMEOUT_CYCLES(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wr(req_wr),
    .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP),
    .err_irq(err_irq), .err_addr(err_addr), .err_clr(err_clr)
  );

  // Clock / cycle counter
  initial forever #5 HCLK = ~HCLK;
  int cyc = 0;
  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  // Scoreboards: responses {accept_cycle, err, rdata}; bus transfers {addr, wr, hsize, hwdata}
  logic [64:0] exp_q[$];
  logic [67:0] exp_bus_q[$];

  bit          ws_rand = 1'b0;
  int          ws_fixed = 0;
  bit          inj_en = 1'b0;
  logic [31:0] inj_addr = 32'h0;
  bit          lat_check = 1'b0;
  bit          wd_check = 1'b0;
  int          ns_run = 0;
  int          ns_max = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || ((a % (32'd1 << sz)) != 32'd0);
  endfunction

  function automatic logic [31:0] rep_fn(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (sz == 2'd1) return {16'h0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  // Driver: call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                      input logic [31:0] wd, input bit cancel);
    int n = 0;
    req_valid = 1'b1; req_addr = a; req_wr = wr; req_size = sz; req_wdata = wd;
    @(negedge HCLK);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge HCLK);
    end
    if (n >= 200) chk("req_accept", 64'(req_ready), 64'd1);
    else if (is_mis(a, sz)) exp_q.push_back({cyc[31:0], 1'b1, 32'h0});
    else if (cancel) exp_q.push_back({cyc[31:0], 1'b1, 32'h0});
    else begin
      exp_bus_q.push_back({a, wr, 1'b0, sz, rep_fn(wd, sz)});
      if (inj_en && a == inj_addr) exp_q.push_back({cyc[31:0], 1'b1, 32'h0});
      else exp_q.push_back({cyc[31:0], 1'b0, wr ? 32'h0 : rd_fn(a)});
    end
    @(posedge HCLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge HCLK);
      n++;
    end
    repeat (2) @(posedge HCLK);
    #1;
    chk("rsp_drain", 64'(exp_q.size()), 64'd0);
    chk("bus_drain", 64'(exp_bus_q.size()), 64'd0);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge HCLK); #1;
    err_clr = 1'b0;
    chk("clr_irq", 64'(err_irq), 64'd0);
    chk("clr_addr", 64'(err_addr), 64'd0);
  endtask

  // Behavioural AHB-Lite slave plus bus-side checks
  initial begin
    logic        s_act = 1'b0;
    logic [31:0] s_addr = '0;
    logic        s_wr = 1'b0;
    logic [31:0] s_wdata = '0;
    int          s_wait = 0;
    bit          s_err = 1'b0;
    bit          s_ph = 1'b0;
    bit          prev_ok = 1'b0;
    logic [37:0] prev_ap = '0;
    int          lowcnt = 0;
    logic [67:0] e;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        s_act = 1'b0; prev_ok = 1'b0; lowcnt = 0; ns_run = 0;
      end else begin
        if (prev_ok) chk("ap_hold", 64'({HTRANS, HADDR, HWRITE, HSIZE}), 64'(prev_ap));
        prev_ok = (HTRANS == 2'b10) && !HREADY && !HRESP;
        prev_ap = {HTRANS, HADDR, HWRITE, HSIZE};
        if (HTRANS == 2'b10) begin
          ns_run++;
          if (ns_run > ns_max) ns_max = ns_run;
        end else ns_run = 0;
        if (wd_check && s_act && !HREADY) begin
          lowcnt++;
          chk("wd_irq", 64'(err_irq), 64'(lowcnt > 8));
        end else lowcnt = 0;
        if (s_act && HREADY && HRESP) chk("cancel_idle", 64'(HTRANS), 64'd0);
        if (s_act && HREADY) begin
          if (s_wr && !HRESP) chk("hwdata", 64'(HWDATA), 64'(s_wdata));
          s_act = 1'b0;
        end
        if (HREADY && HTRANS == 2'b10) begin
          chk("bus_pending", 64'(exp_bus_q.size() != 0), 64'd1);
          if (exp_bus_q.size() != 0) begin
            e = exp_bus_q.pop_front();
            chk("bus_ap", 64'({HADDR, HWRITE, HSIZE}), 64'(e[67:32]));
            s_wdata = e[31:0];
          end
          s_act = 1'b1; s_addr = HADDR; s_wr = HWRITE;
          s_err = inj_en && (HADDR == inj_addr);
          s_ph = 1'b0;
          s_wait = ws_rand ? int'($urandom_range(0, 3)) : ws_fixed;
        end
      end
      @(posedge HCLK); #1;
      if (!s_act) begin
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
      end else if (s_wait > 0) begin
        HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom; s_wait--;
      end else if (s_err) begin
        HRESP = 1'b1; HREADY = s_ph; s_ph = 1'b1; HRDATA = $urandom;
      end else begin
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = s_wr ? $urandom : rd_fn(s_addr);
      end
    end
  end

  // Response scoreboard
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge HCLK);
      if (HRESETn && rsp_valid) begin
        chk("rsp_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp", 64'({rsp_err, rsp_rdata}), 64'(e[32:0]));
          if (lat_check) chk("rsp_latency", 64'(cyc - int'(e[64:33])), 64'd3);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  // Directed sequence
  initial begin
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_htrans", 64'(HTRANS), 64'd0);
    chk("rst_haddr", 64'(HADDR), 64'd0);
    chk("rst_hwdata", 64'(HWDATA), 64'd0);
    chk("rst_hsize", 64'(HSIZE), 64'd0);
    chk("rst_hwrite", 64'(HWRITE), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    chk("rst_err", 64'({err_irq, err_addr}), 64'd0);
    chk("const_ahb", 64'({HBURST, HPROT, HMASTLOCK}), 64'({3'b000, 4'b0011, 1'b0}));
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Back-to-back zero-wait reads
    lat_check = 1'b1; ns_max = 0;
    send(32'h100, 1'b0, 2'd2, 32'h0, 1'b0);
    send(32'h104, 1'b0, 2'd2, 32'h0, 1'b0);
    send(32'h108, 1'b0, 2'd2, 32'h0, 1'b0);
    drain();
    lat_check = 1'b0;
    chk("nonseq_run", 64'(ns_max), 64'd3);

    // Byte write with two wait states
    ws_fixed = 2;
    send(32'h203, 1'b1, 2'd0, 32'h1234_56A5, 1'b0);
    @(posedge HCLK); #1;
    chk("bw_haddr1", 64'(HADDR), 64'h203);
    chk("bw_hwdata", 64'(HWDATA), 64'hA5A5_A5A5);
    @(posedge HCLK); #1;
    chk("bw_haddr2", 64'(HADDR), 64'h203);
    drain();
    ws_fixed = 0;
    chk("no_err_irq", 64'(err_irq), 64'd0);

    // Bus ERROR with a pending address phase
    inj_en = 1'b1; inj_addr = 32'h400;
    send(32'h400, 1'b0, 2'd2, 32'h0, 1'b0);
    send(32'h404, 1'b0, 2'd2, 32'h0, 1'b1);
    drain();
    inj_en = 1'b0;
    chk("buserr_irq", 64'(err_irq), 64'd1);
    chk("buserr_addr", 64'(err_addr), 64'h400);
    clear_err();

    // Misaligned word
    ns_max = 0;
    send(32'h302, 1'b0, 2'd2, 32'h0, 1'b0);
    drain();
    chk("mis_no_nonseq", 64'(ns_max), 64'd0);
    chk("mis_irq", 64'(err_irq), 64'd1);
    chk("mis_addr", 64'(err_addr), 64'h302);
    clear_err();

    // Watchdog
    ws_fixed = 20; wd_check = 1'b1;
    send(32'h500, 1'b0, 2'd2, 32'h0, 1'b0);
    drain();
    wd_check = 1'b0; ws_fixed = 0;
    chk("wd_irq_final", 64'(err_irq), 64'd1);
    chk("wd_addr", 64'(err_addr), 64'h500);
    clear_err();

    // Randomized traffic
    ws_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(32'h1000 + $urandom_range(0, 255), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), $urandom, 1'b0);
      repeat ($urandom_range(0, 1)) begin
        @(posedge HCLK); #1;
      end
    end
    drain();
    ws_rand = 1'b0;

    // Reset with two transfers in flight
    ws_fixed = 4;
    send(32'h600, 1'b0, 2'd2, 32'h0, 1'b0);
    send(32'h604, 1'b1, 2'd2, 32'hDEAD_BEEF, 1'b0);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("arst_htrans", 64'(HTRANS), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_haddr", 64'(HADDR), 64'd0);
    exp_q.delete();
    exp_bus_q.delete();
    repeat (3) @(posedge HCLK);
    #1;
    ws_fixed = 0;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    send(32'h700, 1'b0, 2'd2, 32'h0, 1'b0);
    send(32'h706, 1'b1, 2'd1, 32'h0000_BEEF, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
